// File: rtl/demorgan_pipe.sv
// Two-stage valid/ready pipe that evaluates one of four De Morgan identities in gate and direct form.
// Latency 2 cycles accept->out_valid; full throughput; stages stall in place when downstream is not ready.
module demorgan_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             force_fault,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] na,
    output logic [WIDTH-1:0] nb,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_err
);

    logic             s1_vld_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       mode_q;
    logic             ff_q;

    logic             s2_vld_q;
    logic [WIDTH-1:0] y_q, na_q, nb_q;
    logic             mis_q;

    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] na1, nb1, g, d, fmask, y_d;
    logic             mis_d;
    logic             err_xfer;

    assign s2_adv   = !s2_vld_q || out_ready;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign in_ready = s1_adv;

    assign na1 = ~a_q;
    assign nb1 = ~b_q;

    always_comb begin
        g = '0;
        d = '0;
        case (mode_q)
            2'd0: begin g = na1 & nb1;    d = ~(a_q | b_q); end
            2'd1: begin g = na1 | nb1;    d = ~(a_q & b_q); end
            2'd2: begin g = ~(na1 | nb1); d = a_q & b_q;    end
            default: begin g = ~(na1 & nb1); d = a_q | b_q; end
        endcase
    end

    // Fault mask built bitwise so WIDTH=1 needs no zero-width replication.
    always_comb begin
        fmask    = '0;
        fmask[0] = ff_q;
    end

    assign y_d   = g ^ fmask;
    assign mis_d = (y_d != d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 2'd0;
            ff_q     <= 1'b0;
        end else if (s1_adv) begin
            s1_vld_q <= in_valid;
            if (in_valid) begin
                a_q    <= a;
                b_q    <= b;
                mode_q <= mode;
                ff_q   <= force_fault;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            y_q      <= '0;
            na_q     <= '0;
            nb_q     <= '0;
            mis_q    <= 1'b0;
        end else if (s2_adv) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                y_q   <= y_d;
                na_q  <= na1;
                nb_q  <= nb1;
                mis_q <= mis_d;
            end
        end
    end

    assign err_xfer = s2_vld_q && out_ready && mis_q;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr_err) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (err_xfer) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign y          = y_q;
    assign na         = na_q;
    assign nb         = nb_q;
    assign mismatch   = mis_q;
    assign err_count  = cnt_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_demorgan_pipe.sv
// Directed and randomized checks of demorgan_pipe against a transaction-level queue model.
module tb_demorgan_pipe;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  a, b;
    logic [1:0]    mode;
    logic          force_fault;
    logic          out_valid, out_ready;
    logic [W-1:0]  y, na, nb;
    logic          mismatch, err_sticky;
    logic [CW-1:0] err_count;
    logic          clr_err;

    demorgan_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .force_fault(force_fault),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .na(na), .nb(nb), .mismatch(mismatch),
        .err_sticky(err_sticky), .err_count(err_count), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic [W-1:0] na;
        logic [W-1:0] nb;
        logic         mis;
        int           age;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_cnt    = 0;
    logic m_st     = 1'b0;
    logic last_acc = 1'b0;
    localparam int CMAX = (1 << CW) - 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Identity results written straight from the Boolean meaning of each mode.
    function automatic exp_t ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                       input logic [1:0] rm, input logic rf);
        exp_t e;
        logic [W-1:0] r;
        case (rm)
            2'd0: r = ~(ra | rb);
            2'd1: r = ~(ra & rb);
            2'd2: r = ra & rb;
            default: r = ra | rb;
        endcase
        e.y   = r ^ {{(W-1){1'b0}}, rf};
        e.na  = ~ra;
        e.nb  = ~rb;
        e.mis = rf;
        e.age = 1;
        return e;
    endfunction

    task automatic cyc();
        logic exp_rdy, exp_ov, acc, xfer, xmis;
        @(negedge clk);
        exp_rdy = (q.size() < 2) || out_ready;
        exp_ov  = (q.size() > 0) && (q[0].age >= 2);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("y", y, q[0].y);
            chk("na", na, q[0].na);
            chk("nb", nb, q[0].nb);
            chk("mismatch", mismatch, q[0].mis);
        end
        chk("err_count", err_count, m_cnt);
        chk("err_sticky", err_sticky, m_st);
        acc  = in_valid && exp_rdy;
        xfer = exp_ov && out_ready;
        xmis = 1'b0;
        if (xfer) begin
            xmis = q[0].mis;
            void'(q.pop_front());
        end
        if (clr_err) begin
            m_cnt = 0;
            m_st  = 1'b0;
        end else if (xfer && xmis) begin
            m_st = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
        end
        foreach (q[i]) q[i].age++;
        if (acc) q.push_back(ref_model(a, b, mode, force_fault));
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [1:0] tm, input logic tf);
        in_valid = v; a = ta; b = tb; mode = tm; force_fault = tf;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
    endtask

    logic [W-1:0] ylist [4];

    initial begin
        ylist = '{8'h03, 8'h3F, 8'hC0, 8'hFC};
        rst_n = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0, 2'd0, 1'b0);
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_y", y, 8'h00);
        chk("rst_na", na, 8'h00);
        chk("rst_nb", nb, 8'h00);
        chk("rst_mismatch", mismatch, 1'b0);
        chk("rst_err_count", err_count, 0);
        chk("rst_err_sticky", err_sticky, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Four identities back-to-back on F0/CC.
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 8'hF0, 8'hCC, 2'(m), 1'b0);
            cyc();
            if (m == 0) chk("lat_not_early", out_valid, 1'b0);
            else        chk("lat_y", y, ylist[m-1]);
        end
        in_valid = 1'b0;
        cyc();
        chk("lat_y_last", y, ylist[3]);
        chk("dir_na", na, 8'h0F);
        chk("dir_nb", nb, 8'h33);
        drain();
        chk("dir_err_count", err_count, 0);

        // Backpressure: third offer must stall until the sink wakes.
        out_ready = 1'b0;
        drive(1'b1, 8'hF0, 8'hCC, 2'd0, 1'b0); cyc();
        drive(1'b1, 8'hF0, 8'hCC, 2'd1, 1'b0); cyc();
        drive(1'b1, 8'hF0, 8'hCC, 2'd2, 1'b0);
        chk("bp_in_ready_low", in_ready, 1'b0);
        cyc(); cyc();
        chk("bp_y_held", y, 8'h03);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        drain();

        // Single fault, then a clean transaction.
        drive(1'b1, 8'hF0, 8'hCC, 2'd0, 1'b1); cyc();
        drive(1'b0, 8'hF0, 8'hCC, 2'd0, 1'b0); cyc();
        chk("fault_y", y, 8'h02);
        chk("fault_mismatch", mismatch, 1'b1);
        cyc();
        chk("fault_count", err_count, 1);
        chk("fault_sticky", err_sticky, 1'b1);
        drive(1'b1, 8'h5A, 8'h3C, 2'd3, 1'b0); cyc();
        drain();
        chk("clean_keeps_count", err_count, 1);

        // Saturation at 3 for a 2-bit counter, then clear.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i * 37), 8'(i * 11), 2'(i), 1'b1);
            cyc();
        end
        drain();
        chk("sat_count", err_count, 3);
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
        chk("clr_count", err_count, 0);
        chk("clr_sticky", err_sticky, 1'b0);

        // Clear in the same cycle as a faulty transfer.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hA5, 8'h0F, 2'd1, 1'b1);
            cyc();
        end
        drain();
        chk("pre_clr_count", err_count, 2);
        drive(1'b1, 8'hA5, 8'h0F, 2'd2, 1'b1); cyc();
        in_valid = 1'b0; cyc();
        chk("race_out_valid", out_valid, 1'b1);
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
        chk("race_count", err_count, 0);
        chk("race_sticky", err_sticky, 1'b0);

        // Randomized traffic with producer hold semantics.
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc)
                drive(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                      2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            out_ready = ($urandom_range(0, 3) != 0);
            clr_err   = ($urandom_range(0, 31) == 0);
            cyc();
        end
        clr_err = 1'b0;
        drain();

        // Reset while both stages are full and stalled.
        out_ready = 1'b0;
        drive(1'b1, 8'h12, 8'h34, 2'd0, 1'b1); cyc();
        drive(1'b1, 8'h56, 8'h78, 2'd1, 1'b1); cyc();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_count", err_count, 0);
        q.delete();
        m_cnt = 0;
        m_st  = 1'b0;
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demorgan_pipe.md
Name: demorgan_pipe

Overview:
Parametrised, pipelined successor to the single-bit De Morgan gate cell. It takes WIDTH-bit operand vectors and selects one of four De Morgan identities per transaction. Each result is computed twice, once in gate form (from the inverted operands) and once in direct form, and the two are compared. A valid/ready handshake carries data through two register stages, and a saturating error counter records gate/direct mismatches for fault-injection and self-check use.

Parameters:
WIDTH, 8, operand/result vector width (>=1)
CNT_W, 8, mismatch counter width (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream transaction present
in_ready  output  1  block can accept a transaction this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
mode  input  2  function select, captured with the operands
force_fault  input  1  invert bit 0 of the gate-form result for this transaction
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
y  output  WIDTH  gate-form result
na  output  WIDTH  registered ~a of this transaction
nb  output  WIDTH  registered ~b of this transaction
mismatch  output  1  gate-form result differs from direct form for this transaction
err_sticky  output  1  set by any accepted mismatching result
err_count  output  CNT_W  count of accepted mismatching results, saturating
clr_err  input  1  synchronous clear of err_sticky and err_count

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, y/na/nb=0, mismatch=0, err_sticky=0, err_count=0. in_ready=1 while the pipe is empty.
- Handshake: a transfer occurs when valid&&ready. Producer-side signals must hold until the transfer. The block never drops or reorders transactions.
- Stage 1 (S1): on accept, registers a, b, mode, force_fault and computes na=~a, nb=~b.
- Stage 2 (S2): from S1, computes the gate form g and direct form d:
  - mode 0: g=na&nb, d=~(a|b)
  - mode 1: g=na|nb, d=~(a&b)
  - mode 2: g=~(na|nb), d=a&b
  - mode 3: g=~(na&nb), d=a|b
  - y=g^{WIDTH-1 zeros, force_fault}
  - mismatch=(y!=d)
  - S2 registers y, na, nb and mismatch.
- Flow control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational)
  - S2 loads when s1_valid && s2_adv. S2 clears its valid when it is consumed and not reloaded.
  - Stalled stages hold all registered fields.
- Latency and throughput: 2 cycles from accept to out_valid with out_ready high; 1 transaction per cycle sustained.
- Error accounting: evaluated on each output transfer (out_valid && out_ready && mismatch).
  - err_count increments by 1 and saturates at 2^CNT_W-1, with no wrap.
  - err_sticky is set.
- clr_err priority: clr_err has priority over a same-cycle increment or set. Both err_sticky and err_count read 0 the next cycle.
- mismatch, y, na and nb are meaningful only while out_valid=1.
- Reset mid-operation: all in-flight transactions are discarded immediately. out_valid falls asynchronously. Counters are zeroed.

Test Plan:
- WIDTH=8, a=F0, b=CC, modes 0..3 back-to-back with out_ready=1 -> y=03, 3F, C0, FC on cycles 2..5 after the first accept; na=0F, nb=33; mismatch=0; err_count=0.
- Backpressure: out_ready=0, offer 3 transactions (modes 0, 1, 2) -> first two accepted, in_ready=0 on the third. Raise out_ready -> outputs 03, 3F, C0 in order, each held stable while stalled.
- Fault: a=F0, b=CC, mode 0, force_fault=1 -> y=02, mismatch=1. After the transfer, err_count=1 and err_sticky=1. A following clean transaction leaves the count at 1.
- Saturation with CNT_W=2: 5 faulty transactions accepted -> err_count=3 and holds. clr_err pulse -> err_count=0, err_sticky=0.
- clr_err asserted in the same cycle as a faulty output transfer (err_count=2 beforehand) -> next cycle err_count=0, err_sticky=0.
- Both stages full, rst_n pulsed low mid-stall -> out_valid=0 immediately, in_ready=1 after release. Nothing emitted on the next out_ready.
